// File: rtl/escalonador_movimento_pkg.sv
// Shared definitions for the movement scheduler.
//   estado_t    : 4-bit FSM state codes, also exported on db_estado
//   sel_cfg_t   : {coordinate mux, increment mux, add/sub} routing triple
//   SEL_ASTEROIDE / SEL_TIRO : routing for asteroid and shot items
package escalonador_movimento_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    ESPERA_TICK  = 4'd1,
    SELECIONA    = 4'd2,
    CALCULA      = 4'd3,
    GRAVA        = 4'd4,
    CALCULA_TIRO = 4'd5,
    GRAVA_TIRO   = 4'd6,
    FIM          = 4'd7
  } estado_t;

  typedef struct packed {
    logic coor;        // 0 = asteroid coordinate, 1 = shot coordinate
    logic incremento;  // 0 = asteroid step, 1 = shot step
    logic sum_sub;     // 0 = add, 1 = subtract
  } sel_cfg_t;

  localparam sel_cfg_t SEL_ASTEROIDE = '{coor: 1'b0, incremento: 1'b0, sum_sub: 1'b0};
  localparam sel_cfg_t SEL_TIRO      = '{coor: 1'b1, incremento: 1'b1, sum_sub: 1'b1};

endpackage

// File: rtl/escalonador_movimento_contador_tick.sv
// contador_tick: modulo-MODULO counter that produces the movement tick.
//   clock    : system clock
//   reset    : asynchronous active-low reset
//   habilita : count enable; when low the count is held at 0
//   tick     : one-cycle pulse on the terminal count (MODULO-1)
module contador_tick #(
  parameter int unsigned MODULO = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic habilita,
  output logic tick
);

  localparam int unsigned W = (MODULO > 1) ? $clog2(MODULO) : 1;
  localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = habilita && (cnt_q == ULTIMO);
    cnt_d = cnt_q;
    if (!habilita) begin
      cnt_d = '0;
    end else if (cnt_q == ULTIMO) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/escalonador_movimento.sv
// escalonador_movimento: sequences asteroid slots and the shot through the
// shared coordinate adder once per movement tick.
//   clock, reset          : clock and asynchronous active-low reset
//   habilita              : run enable from the control unit; low aborts to OCIOSO
//   ativo                 : asteroid active mask, captured at sweep start
//   tiro_pedido           : one-cycle request to move the shot
//   sel_asteroide         : asteroid slot routed to the adder
//   select_mux_coor/_incremento, select_sum_sub : adder routing
//   enable_reg_asteroide  : one-hot asteroid write enable (GRAVA)
//   enable_reg_tiro       : shot register write enable (GRAVA_TIRO)
//   fim_rodada            : pulse in the last cycle of a sweep
//   erro_overrun          : sticky, a tick arrived while one was still pending
//   db_estado             : current state code
module escalonador_movimento
  import escalonador_movimento_pkg::*;
#(
  parameter int unsigned N_AST       = 4,
  parameter int unsigned TICK_CICLOS = 25000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilita,
  input  logic [N_AST-1:0]         ativo,
  input  logic                     tiro_pedido,
  output logic [$clog2(N_AST)-1:0] sel_asteroide,
  output logic                     select_mux_coor,
  output logic                     select_mux_incremento,
  output logic                     select_sum_sub,
  output logic [N_AST-1:0]         enable_reg_asteroide,
  output logic                     enable_reg_tiro,
  output logic                     fim_rodada,
  output logic                     erro_overrun,
  output logic [3:0]               db_estado
);

  localparam int unsigned SEL_W = $clog2(N_AST);

  estado_t          estado_q, estado_d;
  logic             tick;
  logic             tiro_pend_q, tiro_pend_d;
  logic             tick_pend_q, tick_pend_d;
  logic             erro_q, erro_d;
  logic [N_AST-1:0] pend_ast_q, pend_ast_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] prox_idx;
  logic             achado;
  sel_cfg_t         cfg;

  contador_tick #(
    .MODULO(TICK_CICLOS)
  ) u_contador_tick (
    .clock   (clock),
    .reset   (reset),
    .habilita(habilita),
    .tick    (tick)
  );

  // Lowest pending asteroid slot.
  always_comb begin
    prox_idx = '0;
    achado   = 1'b0;
    for (int unsigned i = 0; i < N_AST; i++) begin
      if (!achado && pend_ast_q[SEL_W'(i)]) begin
        prox_idx = SEL_W'(i);
        achado   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:       if (habilita) estado_d = ESPERA_TICK;
      ESPERA_TICK:  if (tick_pend_q) estado_d = SELECIONA;
      SELECIONA: begin
        if (tiro_pend_q) begin
          estado_d = CALCULA_TIRO;
        end else if (achado) begin
          estado_d = CALCULA;
        end else begin
          estado_d = FIM;
        end
      end
      CALCULA:      estado_d = GRAVA;
      GRAVA:        estado_d = SELECIONA;
      CALCULA_TIRO: estado_d = GRAVA_TIRO;
      GRAVA_TIRO:   estado_d = SELECIONA;
      FIM:          estado_d = ESPERA_TICK;
      default:      estado_d = OCIOSO;
    endcase
    if (!habilita) begin
      estado_d = OCIOSO;
    end
  end

  // Pending flags, sweep mask and selected slot.
  always_comb begin
    tiro_pend_d = tiro_pend_q;
    tick_pend_d = tick_pend_q;
    pend_ast_d  = pend_ast_q;
    sel_d       = sel_q;
    erro_d      = erro_q | (tick & tick_pend_q);

    if (estado_q == GRAVA_TIRO) tiro_pend_d = 1'b0;
    if (tiro_pedido)            tiro_pend_d = 1'b1;

    // A tick coinciding with the pending-clear keeps the flag set.
    if (estado_q == ESPERA_TICK && tick_pend_q) begin
      tick_pend_d = 1'b0;
      pend_ast_d  = ativo;
    end
    if (tick) tick_pend_d = 1'b1;

    if (estado_q == GRAVA) pend_ast_d[sel_q] = 1'b0;

    if (estado_q == SELECIONA && !tiro_pend_q && achado) sel_d = prox_idx;

    // Abort: drop all pending work; the overrun flag survives.
    if (!habilita) begin
      tiro_pend_d = 1'b0;
      tick_pend_d = 1'b0;
      pend_ast_d  = '0;
      sel_d       = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tiro_pend_q <= 1'b0;
      tick_pend_q <= 1'b0;
      erro_q      <= 1'b0;
      pend_ast_q  <= '0;
      sel_q       <= '0;
    end else begin
      tiro_pend_q <= tiro_pend_d;
      tick_pend_q <= tick_pend_d;
      erro_q      <= erro_d;
      pend_ast_q  <= pend_ast_d;
      sel_q       <= sel_d;
    end
  end

  // Output logic. Enables are also gated by habilita so an abort never writes.
  always_comb begin
    cfg                  = SEL_ASTEROIDE;
    enable_reg_asteroide = '0;
    enable_reg_tiro      = 1'b0;
    fim_rodada           = 1'b0;
    unique case (estado_q)
      CALCULA_TIRO: cfg = SEL_TIRO;
      GRAVA_TIRO: begin
        cfg             = SEL_TIRO;
        enable_reg_tiro = habilita;
      end
      GRAVA:        enable_reg_asteroide[sel_q] = habilita;
      FIM:          fim_rodada = 1'b1;
      default:      cfg = SEL_ASTEROIDE;
    endcase
  end

  assign select_mux_coor       = cfg.coor;
  assign select_mux_incremento = cfg.incremento;
  assign select_sum_sub        = cfg.sum_sub;
  assign sel_asteroide         = sel_q;
  assign erro_overrun          = erro_q;
  assign db_estado             = estado_q;

endmodule
